instr_sequencer: RTL and testbench

Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback. It consumes the instruction decoder's class flags (ALUop/MEMop/IMMop/MOVop) and the raw opcode. It drives IR load, PC increment, ALU enable, register-file write, writeback-mux select and the data-memory handshake. It sits between the instruction register/decoder and the datapath, memory and register file.

---
 rtl/instr_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle control FSM that moves one instruction at a time through
// FETCH -> DECODE -> (EXEC | MEM) -> WB. It takes the decoder class flags and
// the opcode, and drives the IR load, PC increment, ALU enable, register-file
// write and writeback-mux select. It also runs the data-memory request/ack
// handshake and guards it with a timeout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 1 = keep executing, 0 = stop at the next instruction boundary
//   instr_valid         instruction word at the IR input is valid
//   opcode              4-bit opcode from the decoder
//   ALUop/MEMop/IMMop/MOVop  decoder class flags
//   dmem_ack            data memory completes the request this cycle
//   ir_load, pc_inc, alu_en, reg_we, wb_sel[1:0]   datapath controls
//   dmem_req, dmem_we   data-memory request (held until ack) and store select
//   busy, halted, err   status (err is sticky until reset)
//   retired_cnt         retired-instruction counter, wraps
//   step                (only with ISEQ_SINGLE_STEP_EN) one instruction per pulse
//
// Optional feature macro: ISEQ_SINGLE_STEP_EN adds the step input.
module instr_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             instr_valid,
    input  logic [3:0]       opcode,
    input  logic             ALUop,
    input  logic             MEMop,
    input  logic             IMMop,
    input  logic             MOVop,
    input  logic             dmem_ack,
`ifdef ISEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             ir_load,
    output logic             pc_inc,
    output logic             alu_en,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Instruction class captured in DECODE so that later states do not depend
    // on the decoder inputs staying stable.
    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_ALU   = 3'd1,
        C_IMM   = 3'd2,
        C_MOV   = 3'd3,
        C_LOAD  = 3'd4,
        C_STORE = 3'd5
    } cls_t;

    // Last MEM cycle index (counter counts completed MEM cycles from 0).
    localparam logic [7:0]       TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    cls_t             cls_r;
    cls_t             cls_s;
    logic [7:0]       tmo_cnt_r;
    logic [CNT_W-1:0] retired_r;
    logic             fetch_go_s;

    // Writeback source for a class; ALU (00) whenever nothing is written.
    function automatic logic [1:0] wb_sel_of(input cls_t c);
        case (c)
            C_IMM:   wb_sel_of = 2'b01;
            C_MOV:   wb_sel_of = 2'b10;
            C_LOAD:  wb_sel_of = 2'b11;
            default: wb_sel_of = 2'b00;
        endcase
    endfunction

    // Classes that write the register file.
    function automatic logic reg_we_of(input cls_t c);
        case (c)
            C_ALU, C_IMM, C_MOV, C_LOAD: reg_we_of = 1'b1;
            default:                     reg_we_of = 1'b0;
        endcase
    endfunction

`ifdef ISEQ_SINGLE_STEP_EN
    logic step_used_r;

    // Remember that the current step level already loaded an instruction;
    // it is re-armed only once step returns low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_used_r <= 1'b0;
        end else if ((state_r == S_FETCH) && fetch_go_s) begin
            step_used_r <= 1'b1;
        end else if (!step) begin
            step_used_r <= 1'b0;
        end
    end

    assign fetch_go_s = instr_valid & step & ~step_used_r;
`else
    assign fetch_go_s = instr_valid;
`endif

    // Class decode from the decoder flags; memory takes priority like the branch.
    always_comb begin
        cls_s = C_NONE;
        if (MEMop) begin
            cls_s = opcode[0] ? C_STORE : C_LOAD;
        end else if (ALUop) begin
            cls_s = C_ALU;
        end else if (IMMop) begin
            cls_s = C_IMM;
        end else if (MOVop) begin
            cls_s = C_MOV;
        end else begin
            cls_s = C_NONE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:   state_nxt_s = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_nxt_s = fetch_go_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == 4'b1111) begin
                    state_nxt_s = S_HALT;
                end else if (MEMop) begin
                    state_nxt_s = S_MEM;
                end else if (ALUop | IMMop | MOVop) begin
                    state_nxt_s = S_EXEC;
                end else begin
                    state_nxt_s = S_WB;
                end
            end
            S_EXEC:   state_nxt_s = S_WB;
            S_MEM: begin
                // An ack in the expiring cycle still completes the access.
                if (dmem_ack) begin
                    state_nxt_s = S_WB;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB:     state_nxt_s = run ? S_FETCH : S_IDLE;
            S_HALT:   state_nxt_s = S_HALT;
            S_ERR:    state_nxt_s = S_ERR;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Capture the instruction class while in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_r <= C_NONE;
        end else if (state_r == S_DECODE) begin
            cls_r <= cls_s;
        end
    end

    // Memory timeout counter: counts MEM cycles, clears whenever MEM is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 8'd0;
        end else if ((state_r == S_MEM) && (state_nxt_s == S_MEM)) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= 8'd0;
        end
    end

    // Retired-instruction counter, advanced once per WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (state_r == S_WB) begin
            retired_r <= retired_r + CNT_ONE;
        end
    end

    assign retired_cnt = retired_r;

    // Output decode (Moore on state, except ir_load which also needs instr_valid).
    always_comb begin
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 2'b00;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        case (state_r)
            S_FETCH: begin
                busy    = 1'b1;
                ir_load = fetch_go_s;
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy   = 1'b1;
                alu_en = (cls_r == C_ALU);
            end
            S_MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (cls_r == C_STORE);
            end
            S_WB: begin
                busy   = 1'b1;
                pc_inc = 1'b1;
                reg_we = reg_we_of(cls_r);
                wb_sel = wb_sel_of(cls_r);
            end
            S_HALT:  halted = 1'b1;
            S_ERR: begin
                halted = 1'b1;
                err    = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a constant vector table, randomized
// instructions checked against a transaction-level model, and hand-written
// sequences for timeout, HALT, run drop, counter wrap and mid-MEM reset.
// The counter is built 8 bits wide so the wrap case stays short.
module tb_instr_sequencer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic             instr_valid;
    logic [3:0]       opcode;
    logic             ALUop, MEMop, IMMop, MOVop;
    logic             dmem_ack;
    logic             ir_load, pc_inc, alu_en, reg_we;
    logic [1:0]       wb_sel;
    logic             dmem_req, dmem_we, busy, halted, err;
    logic [CNT_W-1:0] retired_cnt;

    int n_checks;
    int n_err;

    instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr_valid(instr_valid),
        .opcode(opcode), .ALUop(ALUop), .MEMop(MEMop), .IMMop(IMMop), .MOVop(MOVop),
        .dmem_ack(dmem_ack),
`ifdef ISEQ_SINGLE_STEP_EN
        .step(instr_valid),
`endif
        .ir_load(ir_load), .pc_inc(pc_inc), .alu_en(alu_en), .reg_we(reg_we),
        .wb_sel(wb_sel), .dmem_req(dmem_req), .dmem_we(dmem_we), .busy(busy),
        .halted(halted), .err(err), .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decoder as seen by the sequencer.
    task automatic set_op(input logic [3:0] op);
        opcode = op;
        ALUop  = (op >= 4'd1)  && (op <= 4'd7);
        IMMop  = (op == 4'd8)  || (op == 4'd9);
        MOVop  = (op == 4'd10) || (op == 4'd11);
        MEMop  = (op == 4'd12) || (op == 4'd13);
    endtask

    // Transaction-level model: what one instruction must look like.
    task automatic model(input logic [3:0] op, input int w, output int lat, output int alu_n,
                         output int req_n, output logic mwe, output logic rwe,
                         output logic [1:0] wsel);
        lat = 3; alu_n = 0; req_n = 0; mwe = 1'b0; rwe = 1'b0; wsel = 2'b00;
        if (op >= 4'd1 && op <= 4'd7) begin
            lat = 4; alu_n = 1; rwe = 1'b1; wsel = 2'b00;
        end else if (op == 4'd8 || op == 4'd9) begin
            lat = 4; rwe = 1'b1; wsel = 2'b01;
        end else if (op == 4'd10 || op == 4'd11) begin
            lat = 4; rwe = 1'b1; wsel = 2'b10;
        end else if (op == 4'd12) begin
            lat = 3 + w; req_n = w; rwe = 1'b1; wsel = 2'b11;
        end else if (op == 4'd13) begin
            lat = 3 + w; req_n = w; mwe = 1'b1;
        end
    endtask

    // Observed results of the last run_instr call.
    int         r_lat, r_alu, r_req;
    logic       r_mwe, r_rwe;
    logic [1:0] r_wsel;
    bit         r_pc;

    // Present one instruction and observe it until pc_inc or halted.
    // Called and returning 1 time unit after a rising edge.
    task automatic run_instr(input logic [3:0] op, input int gap, input int ack_w,
                             input bit drop_run);
        int  load_cyc;
        bit  done;
        load_cyc = -1; done = 1'b0;
        r_lat = -1; r_alu = 0; r_req = 0; r_mwe = 1'b0; r_rwe = 1'b0; r_wsel = 2'b00; r_pc = 1'b0;
        set_op(op);
        for (int k = 0; k < 300 && !done; k++) begin
            instr_valid = (k >= gap) && (load_cyc < 0);
            @(negedge clk);
            if (ir_load) load_cyc = k;
            if (alu_en) begin
                r_alu++;
                if (drop_run) run = 1'b0;
            end
            if (dmem_req) begin
                r_req++;
                r_mwe    = dmem_we;
                dmem_ack = (r_req == ack_w);
            end
            if (pc_inc) begin
                r_pc = 1'b1; r_lat = k - load_cyc + 1; r_rwe = reg_we; r_wsel = wb_sel; done = 1'b1;
            end
            if (halted) done = 1'b1;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        instr_valid = 1'b0;
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL instr_timeout: op %0h never completed", op);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; dmem_ack = 1'b0; set_op(4'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] op; int w; int lat; int alu_n; int req_n;
        logic mwe; logic rwe; logic [1:0] wsel;
    } vec_t;

    vec_t       tbl[9];
    logic [CNT_W-1:0] exp_ret;
    int         e_lat, e_alu, e_req;
    logic       e_mwe, e_rwe;
    logic [1:0] e_wsel;
    int         cnt;
    bit         seen;

    initial begin
        n_checks = 0; n_err = 0;
        tbl[0] = '{4'b0011, 0,  4, 1, 0,  1'b0, 1'b1, 2'b00};
        tbl[1] = '{4'b1000, 0,  4, 0, 0,  1'b0, 1'b1, 2'b01};
        tbl[2] = '{4'b1011, 0,  4, 0, 0,  1'b0, 1'b1, 2'b10};
        tbl[3] = '{4'b1100, 3,  6, 0, 3,  1'b0, 1'b1, 2'b11};
        tbl[4] = '{4'b1101, 3,  6, 0, 3,  1'b1, 1'b0, 2'b00};
        tbl[5] = '{4'b0000, 0,  3, 0, 0,  1'b0, 1'b0, 2'b00};
        tbl[6] = '{4'b1110, 0,  3, 0, 0,  1'b0, 1'b0, 2'b00};
        tbl[7] = '{4'b1101, 1,  4, 0, 1,  1'b1, 1'b0, 2'b00};
        tbl[8] = '{4'b1100, 15, 18, 0, 15, 1'b0, 1'b1, 2'b11};

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_outputs", {ir_load, pc_inc, alu_en, reg_we, wb_sel, dmem_req, dmem_we,
                            busy, halted, err}, 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b1;
        exp_ret = '0;

        // Table-driven vectors, including ack on the last allowed MEM cycle.
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, 0, tbl[i].w, 1'b0);
            exp_ret = exp_ret + 8'd1;
            chk($sformatf("tbl%0d_pc", i),   r_pc,   1);
            chk($sformatf("tbl%0d_lat", i),  r_lat,  tbl[i].lat);
            chk($sformatf("tbl%0d_alu", i),  r_alu,  tbl[i].alu_n);
            chk($sformatf("tbl%0d_req", i),  r_req,  tbl[i].req_n);
            if (tbl[i].req_n > 0) chk($sformatf("tbl%0d_mwe", i), r_mwe, tbl[i].mwe);
            chk($sformatf("tbl%0d_rwe", i),  r_rwe,  tbl[i].rwe);
            chk($sformatf("tbl%0d_wsel", i), r_wsel, tbl[i].wsel);
            chk($sformatf("tbl%0d_ret", i),  retired_cnt, exp_ret);
        end
        @(negedge clk);
        chk("ack_last_err", err, 1'b0);
        @(posedge clk); #1;

        // Randomized instructions against the model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            int w, g;
            op = 4'($urandom_range(0, 14));
            w  = $urandom_range(1, 6);
            g  = $urandom_range(0, 3);
            model(op, w, e_lat, e_alu, e_req, e_mwe, e_rwe, e_wsel);
            run_instr(op, g, w, 1'b0);
            exp_ret = exp_ret + 8'd1;
            chk("rnd_pc", r_pc, 1);
            chk("rnd_lat", r_lat, e_lat);
            chk("rnd_alu", r_alu, e_alu);
            chk("rnd_req", r_req, e_req);
            if (e_req > 0) chk("rnd_mwe", r_mwe, e_mwe);
            chk("rnd_rwe", r_rwe, e_rwe);
            chk("rnd_wsel", r_wsel, e_wsel);
            chk("rnd_ret", retired_cnt, exp_ret);
        end

        // run dropped during EXEC: instruction completes, then IDLE.
        run_instr(4'b0011, 0, 0, 1'b1);
        exp_ret = exp_ret + 8'd1;
        chk("drop_pc", r_pc, 1);
        chk("drop_rwe", r_rwe, 1'b1);
        chk("drop_ret", retired_cnt, exp_ret);
        instr_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ir_load || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("drop_idle", seen, 1'b0);
        run = 1'b1;
        @(negedge clk);
        chk("rerun_idle_cycle", ir_load, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rerun_fetch", ir_load, 1'b1);
        @(posedge clk); #1;
        instr_valid = 1'b0;

        // Store without ack: timeout into ERR.
        do_reset();
        rst_n = 1'b1; run = 1'b1;
        run_instr(4'b1101, 0, 0, 1'b0);
        chk("tmo_pc", r_pc, 0);
        chk("tmo_req", r_req, 15);
        @(negedge clk);
        chk("tmo_flags", {err, halted, dmem_req, busy, pc_inc}, 5'b11000);
        chk("tmo_ret", retired_cnt, 32'd0);
        @(posedge clk); #1;

        // NOP, reserved, HALT.
        do_reset();
        rst_n = 1'b1; run = 1'b1;
        run_instr(4'b0000, 0, 0, 1'b0);
        chk("nop_lat", r_lat, 3);
        chk("nop_rwe", r_rwe, 1'b0);
        run_instr(4'b1110, 1, 0, 1'b0);
        chk("rsv_lat", r_lat, 3);
        chk("rsv_rwe", r_rwe, 1'b0);
        run_instr(4'b1111, 0, 0, 1'b0);
        chk("halt_pc", r_pc, 0);
        instr_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ir_load || pc_inc || busy || !halted) seen = 1'b1;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        chk("halt_sticky", seen, 1'b0);
        chk("halt_ret", retired_cnt, 32'd2);
        chk("halt_err", err, 1'b0);

        // Counter wrap with back-to-back NOPs.
        do_reset();
        rst_n = 1'b1; run = 1'b1; set_op(4'b0000); instr_valid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3000 && cnt < 256; k++) begin
            @(negedge clk);
            seen = pc_inc;
            @(posedge clk); #1;
            if (seen) begin
                cnt++;
                if (cnt == 255) chk("wrap_ff", retired_cnt, 32'hFF);
                if (cnt == 256) chk("wrap_zero", retired_cnt, 32'd0);
            end
        end
        chk("wrap_count", cnt, 256);
        instr_valid = 1'b0;

        // Reset asserted in the middle of a MEM access.
        do_reset();
        rst_n = 1'b1; run = 1'b1; set_op(4'b1100); instr_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dmem_req) seen = 1'b1;
        end
        chk("mid_mem_req", seen, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", dmem_req, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", {busy, halted, ir_load}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
